// File: rtl/gmii_rx_framer.sv
// gmii_rx_framer
// Strips preamble/SFD from a GMII receive stream, checks CRC-32 and frame length, and forwards the
// frame bytes to the 8-to-256 packer with an end-of-frame verdict and good/bad frame counters.
// Build option: define GMII_RX_FRAMER_FCS_STRIP_EN to hold the 4 FCS bytes back in a delay line
// so they never reach rxd (5-cycle latency instead of 1).
module gmii_rx_framer #(
  parameter int unsigned MIN_LEN = 64,
  parameter int unsigned MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        RSTN,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  output logic [7:0]  rxd,
  output logic        rxen,
  output logic        frame_done,
  output logic        frame_ok,
  output logic [10:0] frame_len,
  output logic [15:0] cnt_ok,
  output logic [15:0] cnt_bad
);

  localparam logic [7:0]  Preamble    = 8'h55;
  localparam logic [7:0]  Sfd         = 8'hD5;
  localparam logic [31:0] CrcInit     = 32'hFFFF_FFFF;
  localparam logic [31:0] CrcPolyRefl = 32'hEDB8_8320;
  // 0xC704DD7B expressed in the bit order of the reflected (LSB-first) CRC register.
  localparam logic [31:0] CrcResidue  = 32'hDEBB_20E3;
  localparam logic [10:0] LenSat      = 11'h7FF;

  typedef enum logic [1:0] {StIdle, StPreamble, StData, StDrop} state_e;

  state_e      state_q, state_d;
  logic        from_data_q, from_data_d;  // DROP was entered from DATA, so a verdict is owed
  logic        dv_prev_q;                 // resets high: a frame already running is not fresh
  logic [31:0] crc_q, crc_d;
  logic [10:0] len_q, len_d;

  logic        push;                      // DATA byte accepted this cycle
  logic        end_frame;
  logic        end_good;
  logic        len_in_range;

  logic [7:0]  rxd_q, rxd_d;
  logic        rxen_q, rxen_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic [10:0] flen_q, flen_d;
  logic [15:0] cnt_ok_q, cnt_ok_d;
  logic [15:0] cnt_bad_q, cnt_bad_d;

`ifdef GMII_RX_FRAMER_FCS_STRIP_EN
  logic [3:0][7:0] dly_q, dly_d;          // [0] newest, [3] oldest
`endif

  // Reflected CRC-32 update, data bits taken LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ CrcPolyRefl;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Saturated 2047 always fails, whatever MAX_LEN is set to.
  assign len_in_range = (len_q != LenSat) && (32'(len_q) >= MIN_LEN) &&
                        (32'(len_q) <= MAX_LEN);

  // Receive FSM plus frame verdict and counter updates.
  always_comb begin
    state_d     = state_q;
    from_data_d = from_data_q;
    crc_d       = crc_q;
    len_d       = len_q;
    push        = 1'b0;
    end_frame   = 1'b0;
    end_good    = 1'b0;
    done_d      = 1'b0;
    ok_d        = 1'b0;
    flen_d      = flen_q;
    cnt_ok_d    = cnt_ok_q;
    cnt_bad_d   = cnt_bad_q;

    unique case (state_q)
      StIdle: begin
        if (gmii_rx_dv) begin
          from_data_d = 1'b0;
          if (dv_prev_q) begin
            state_d = StDrop;
          end else if (gmii_rxd == Preamble) begin
            state_d = StPreamble;
          end else if (gmii_rxd == Sfd) begin
            state_d = StData;
            crc_d   = CrcInit;
            len_d   = '0;
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPreamble: begin
        if (!gmii_rx_dv) begin
          state_d = StIdle;
        end else if (gmii_rx_er) begin
          state_d     = StDrop;
          from_data_d = 1'b0;
        end else if (gmii_rxd == Sfd) begin
          state_d = StData;
          crc_d   = CrcInit;
          len_d   = '0;
        end else if (gmii_rxd != Preamble) begin
          state_d     = StDrop;
          from_data_d = 1'b0;
        end
      end
      StData: begin
        if (!gmii_rx_dv) begin
          state_d   = StIdle;
          end_frame = 1'b1;
          end_good  = (crc_q == CrcResidue) && len_in_range;
        end else if (gmii_rx_er) begin
          state_d     = StDrop;
          from_data_d = 1'b1;
        end else begin
          push  = 1'b1;
          crc_d = crc32_byte(crc_q, gmii_rxd);
          if (len_q != LenSat) len_d = len_q + 11'd1;
        end
      end
      StDrop: begin
        if (!gmii_rx_dv) begin
          state_d     = StIdle;
          end_frame   = from_data_q;
          from_data_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (end_frame) begin
      done_d = 1'b1;
      ok_d   = end_good;
      flen_d = len_q;
      if (end_good) cnt_ok_d  = cnt_ok_q + 16'd1;
      else          cnt_bad_d = cnt_bad_q + 16'd1;
    end
  end

  // Output byte path; rxd is forced to zero whenever rxen is low.
  always_comb begin
    rxd_d  = 8'h00;
    rxen_d = 1'b0;
`ifdef GMII_RX_FRAMER_FCS_STRIP_EN
    dly_d  = dly_q;
    if (push) begin
      dly_d = {dly_q[2:0], gmii_rxd};
      // Only once four bytes are buffered is the oldest one known not to be FCS.
      if (len_q >= 11'd4) begin
        rxd_d  = dly_q[3];
        rxen_d = 1'b1;
      end
    end
`else
    if (push) begin
      rxd_d  = gmii_rxd;
      rxen_d = 1'b1;
    end
`endif
  end

  // FSM, CRC and length registers.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= StIdle;
      from_data_q <= 1'b0;
      dv_prev_q   <= 1'b1;
      crc_q       <= CrcInit;
      len_q       <= '0;
    end else begin
      state_q     <= state_d;
      from_data_q <= from_data_d;
      dv_prev_q   <= gmii_rx_dv;
      crc_q       <= crc_d;
      len_q       <= len_d;
    end
  end

  // Output, status and counter registers.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      rxd_q     <= 8'h00;
      rxen_q    <= 1'b0;
      done_q    <= 1'b0;
      ok_q      <= 1'b0;
      flen_q    <= '0;
      cnt_ok_q  <= '0;
      cnt_bad_q <= '0;
    end else begin
      rxd_q     <= rxd_d;
      rxen_q    <= rxen_d;
      done_q    <= done_d;
      ok_q      <= ok_d;
      flen_q    <= flen_d;
      cnt_ok_q  <= cnt_ok_d;
      cnt_bad_q <= cnt_bad_d;
    end
  end

`ifdef GMII_RX_FRAMER_FCS_STRIP_EN
  // FCS hold-back delay line.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) dly_q <= '0;
    else       dly_q <= dly_d;
  end
`endif

  assign rxd        = rxd_q;
  assign rxen       = rxen_q;
  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign frame_len  = flen_q;
  assign cnt_ok     = cnt_ok_q;
  assign cnt_bad    = cnt_bad_q;

endmodule
